// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, synchronizer depth and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_tgt_state_t;

  localparam int SYNC_STAGES = 2;

  // SDA level seen on the bus during the ninth clock
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  // Open-drain pad: pulling low is the only way to produce a 0 on the bus
  function automatic logic oe_for_level(input logic lvl);
    return ~lvl;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream channel (tvalid/tready/tdata) with master and slave views.
interface axis_if #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/i2c_line_sync.sv
// Pad synchronizers for SCL/SDA plus SCL edge and START/STOP condition detection.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;

  // Multi-flop synchronizers; pure delay lines, so no reset is needed
  always_ff @(posedge clk) begin
    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
  end

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign sda_s   = r_sda_sync[SYNC_STAGES-1];

  // One more stage for edge detection; it always tracks the synced lines so
  // leaving reset never manufactures an edge out of stale state
  always_ff @(posedge clk) begin
    r_scl_d <= w_scl_s;
    r_sda_d <= sda_s;
  end

  assign scl_rise = w_scl_s & ~r_scl_d;
  assign scl_fall = ~w_scl_s & r_scl_d;
  // SDA may only move while SCL is high for START/STOP
  assign start    = w_scl_s & r_scl_d & r_sda_d & ~sda_s;
  assign stop     = w_scl_s & r_scl_d & ~r_sda_d & sda_s;

endmodule

// File: rtl/axis_i2c_target.sv
// Write-only I2C target: receives bytes from a bus controller and packs them
// MSB-first into AXIS_DATA_WIDTH-bit words on an AXI-Stream master port.
module axis_i2c_target
  import i2c_pkg::*;
#(
  parameter int         AXIS_DATA_WIDTH = 16,
  parameter logic [6:0] TARGET_ADDR     = 7'h50
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     scl_i,
  input  logic     sda_i,
  output logic     sda_oe,
  axis_if.master   m_axis,
  output logic     busy,
  output logic     overrun
);

  localparam int               BYTES    = AXIS_DATA_WIDTH / 8;
  localparam int               IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_sda_s;

  i2c_tgt_state_t              r_state;
  logic [2:0]                  r_bit_cnt;
  logic [7:0]                  r_shift;
  logic                        r_ack_drv;
  logic                        r_nack;
  logic [IDX_W-1:0]            r_byte_idx;
  logic [AXIS_DATA_WIDTH-1:0]  r_acc;
  logic [AXIS_DATA_WIDTH-1:0]  r_tdata;
  logic                        r_tvalid;
  logic                        r_sda_oe;
  logic                        r_busy;
  logic                        r_overrun;

  logic [7:0]                  w_byte;
  logic                        w_byte_done;
  logic                        w_addr_match;
  logic                        w_last;
  logic                        w_refuse;
  logic                        w_take;
  logic [AXIS_DATA_WIDTH-1:0]  w_acc_next;

  i2c_line_sync u_sync (
    .clk      (clk),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop),
    .sda_s    (w_sda_s)
  );

  assign w_byte       = {r_shift[6:0], w_sda_s};
  assign w_byte_done  = w_scl_rise && (r_bit_cnt == 3'd7);
  assign w_addr_match = (w_byte[7:1] == TARGET_ADDR) && (w_byte[0] == 1'b0);
  assign w_last       = (r_byte_idx == LAST_IDX);
  // A word-completing byte is refused only when the held word cannot leave this cycle
  assign w_refuse     = w_last && r_tvalid && !m_axis.tready;
  assign w_take       = !rst && !w_stop && !w_start && (r_state == ST_DATA) &&
                        w_byte_done && !w_refuse;
  assign w_acc_next   = (r_acc << 8) | AXIS_DATA_WIDTH'(w_byte);

  // Bus protocol FSM, bit shifter, ACK driver and byte-index bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_ack_drv  <= 1'b0;
      r_nack     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_byte_idx <= '0;
      r_acc      <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (w_stop) begin
        // STOP outranks any SCL edge seen in the same cycle
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 3'd0;
        r_ack_drv  <= 1'b0;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_byte_idx <= '0;
        r_acc      <= '0;
      end else if (w_start) begin
        // Fresh or repeated START: any partial word is dropped
        r_state    <= ST_ADDR;
        r_bit_cnt  <= 3'd0;
        r_ack_drv  <= 1'b0;
        r_sda_oe   <= 1'b0;
        r_byte_idx <= '0;
        r_acc      <= '0;
      end else begin
        case (r_state)
          ST_ADDR, ST_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ST_ADDR) begin
                  if (w_addr_match) begin
                    r_state <= ST_ADDR_ACK;
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end else begin
                  r_state   <= ST_DATA_ACK;
                  r_nack    <= w_refuse;
                  r_overrun <= w_refuse;
                  if (!w_refuse) begin
                    if (w_last) begin
                      r_byte_idx <= '0;
                      r_acc      <= '0;
                    end else begin
                      r_byte_idx <= r_byte_idx + IDX_W'(1);
                      r_acc      <= w_acc_next;
                    end
                  end
                end
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            // First falling edge starts the ninth bit, the second one ends it
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                if (r_state == ST_ADDR_ACK) begin
                  r_sda_oe <= oe_for_level(SDA_ACK);
                end else begin
                  r_sda_oe <= oe_for_level(r_nack ? SDA_NACK : SDA_ACK);
                end
              end else begin
                r_ack_drv <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= ST_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // AXIS output register: a completing word may load in the same cycle the old one drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else if (w_take && w_last) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_acc_next;
    end else if (r_tvalid && m_axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign sda_oe        = r_sda_oe;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;

endmodule
